// File: rtl/mem_access_if.sv
// Data-bus request/acknowledge interface between the MEM-stage load/store engine and memory.
// The master drives a registered request; the slave returns a one-cycle ack with read data.
interface mem_access_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, sel, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, sel, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_access.sv
// MEM-stage load/store engine: big-endian byte lanes, ack timeout and stall request to ctrl.
// Optional `MEM_ALIGN_CHECK_EN rejects misaligned halfword/word accesses without a bus cycle.
module mem_access #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    input  logic [4:0]   ex_wd,
    input  logic         ex_wreg,
    input  logic [31:0]  ex_wdata,
    input  logic         ex_whilo,
    input  logic [31:0]  ex_hi,
    input  logic [31:0]  ex_lo,
    input  logic [7:0]   ex_aluop,
    input  logic [31:0]  ex_mem_addr,
    input  logic [31:0]  ex_reg2,
    output logic [4:0]   mem_wd,
    output logic         mem_wreg,
    output logic [31:0]  mem_wdata,
    output logic         mem_whilo,
    output logic [31:0]  mem_hi,
    output logic [31:0]  mem_lo,
    output logic         stallreq,
    mem_access_if.master dbus,
    output logic         bus_err
);

    localparam logic [7:0]  EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0]  EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0]  EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0]  EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0]  EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0]  EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0]  EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0]  EXE_SW_OP  = 8'b1110_1011;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic [7:0]  CNT_LAST   = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic        aborted;
    logic [31:0] rdata_q;

    logic        is_load, is_store, is_mem, is_half, is_word;
    logic        align_fault;
    logic [3:0]  st_sel;
    logic [31:0] st_wdata;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    // Only stall[4] (mem_wb held) matters here; the other stages are ctrl's business.
    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[3:0]};

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        is_load = 1'b0;
        is_store = 1'b0;
        is_half = 1'b0;
        is_word = 1'b0;
        st_sel = 4'b1111;
        st_wdata = ex_reg2;
        case (ex_aluop)
            EXE_LB_OP, EXE_LBU_OP: is_load = 1'b1;
            EXE_LH_OP, EXE_LHU_OP: begin is_load = 1'b1; is_half = 1'b1; end
            EXE_LW_OP:             begin is_load = 1'b1; is_word = 1'b1; end
            EXE_SB_OP: begin
                is_store = 1'b1;
                st_sel = 4'b1000 >> ex_mem_addr[1:0];
                st_wdata = {4{ex_reg2[7:0]}};
            end
            EXE_SH_OP: begin
                is_store = 1'b1;
                is_half = 1'b1;
                st_sel = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
                st_wdata = {2{ex_reg2[15:0]}};
            end
            EXE_SW_OP: begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
        is_mem = is_load | is_store;
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign align_fault = (is_half && ex_mem_addr[0]) || (is_word && (ex_mem_addr[1:0] != 2'b00));
`else
    assign align_fault = 1'b0;
`endif

    // Big-endian lanes: address offset 0 is the most significant byte.
    always_comb begin
        case (ex_mem_addr[1:0])
            2'b00:   load_byte = rdata_q[31:24];
            2'b01:   load_byte = rdata_q[23:16];
            2'b10:   load_byte = rdata_q[15:8];
            default: load_byte = rdata_q[7:0];
        endcase
        load_half = ex_mem_addr[1] ? rdata_q[15:0] : rdata_q[31:16];
        case (ex_aluop)
            EXE_LB_OP:  load_data = {{24{load_byte[7]}}, load_byte};
            EXE_LBU_OP: load_data = {24'h0, load_byte};
            EXE_LH_OP:  load_data = {{16{load_half[15]}}, load_half};
            EXE_LHU_OP: load_data = {16'h0, load_half};
            default:    load_data = rdata_q;
        endcase
    end

    always_comb begin
        mem_wd    = ex_wd;
        mem_wreg  = ex_wreg;
        mem_wdata = ex_wdata;
        mem_whilo = ex_whilo;
        mem_hi    = ex_hi;
        mem_lo    = ex_lo;
        stallreq  = 1'b0;
        case (state)
            IDLE: begin
                if (is_mem) begin
                    stallreq = 1'b1;
                    mem_wreg = 1'b0;
                end
            end
            BUSY: begin
                stallreq = 1'b1;
                mem_wreg = 1'b0;
            end
            default: begin
                mem_wreg = ex_wreg & ~aborted & ~is_store;
                if (is_load) mem_wdata = load_data;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            aborted    <= 1'b0;
            rdata_q    <= ZERO_WORD;
            dbus.req   <= 1'b0;
            dbus.we    <= 1'b0;
            dbus.addr  <= ZERO_WORD;
            dbus.sel   <= 4'b0000;
            dbus.wdata <= ZERO_WORD;
            bus_err    <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (is_mem) begin
                        if (align_fault) begin
                            aborted <= 1'b1;
                            bus_err <= 1'b1;
                            state   <= DONE;
                        end else begin
                            dbus.req   <= 1'b1;
                            dbus.we    <= is_store;
                            dbus.addr  <= {ex_mem_addr[31:2], 2'b00};
                            dbus.sel   <= st_sel;
                            dbus.wdata <= st_wdata;
                            cnt        <= 8'd0;
                            aborted    <= 1'b0;
                            state      <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // An ack arriving on the last allowed cycle still completes the transfer.
                    if (dbus.ack) begin
                        rdata_q  <= dbus.rdata;
                        dbus.req <= 1'b0;
                        state    <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        dbus.req <= 1'b0;
                        bus_err  <= 1'b1;
                        aborted  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    if (!stall[4]) state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed load/store/timeout/hold/reset vectors
// with a per-cycle compare against a timeline model derived from the transfer rules.
module tb_mem_access;

    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;
    localparam logic [7:0] OP_OR  = 8'b0010_0101;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        ex_whilo;
    logic [31:0] ex_hi, ex_lo;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_mem_addr, ex_reg2;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi, mem_lo;
    logic        stallreq;
    logic        bus_err;

    mem_access_if dbus ();

    mem_access #(.ACK_TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .ex_wd       (ex_wd),
        .ex_wreg     (ex_wreg),
        .ex_wdata    (ex_wdata),
        .ex_whilo    (ex_whilo),
        .ex_hi       (ex_hi),
        .ex_lo       (ex_lo),
        .ex_aluop    (ex_aluop),
        .ex_mem_addr (ex_mem_addr),
        .ex_reg2     (ex_reg2),
        .mem_wd      (mem_wd),
        .mem_wreg    (mem_wreg),
        .mem_wdata   (mem_wdata),
        .mem_whilo   (mem_whilo),
        .mem_hi      (mem_hi),
        .mem_lo      (mem_lo),
        .stallreq    (stallreq),
        .dbus        (dbus),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected per-cycle values, set by the stimulus and consumed by the compare process.
    bit          chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_err, exp_wreg, exp_wdata_vld, exp_we, exp_store;
    logic [31:0] exp_wdata, exp_addr, exp_bwdata;
    logic [3:0]  exp_sel;
    logic [31:0] last_wdata, last_bwdata, last_addr;
    logic [3:0]  last_sel;
    logic        last_we;

    function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(rdata >> (8 * (3 - int'(addr[1:0]))));
        h = 16'(rdata >> (addr[1] ? 0 : 16));
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'h0, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'h0, h};
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] model_sel(input logic [7:0] op, input logic [31:0] addr);
        case (op)
            OP_SB:   return 4'b1000 >> addr[1:0];
            OP_SH:   return 4'b1100 >> (2 * int'(addr[1]));
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_bwdata(input logic [7:0] op, input logic [31:0] reg2);
        case (op)
            OP_SB:   return {4{reg2[7:0]}};
            OP_SH:   return {2{reg2[15:0]}};
            default: return reg2;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("stallreq", 32'(stallreq), 32'(exp_stall));
            check("dbus_req", 32'(dbus.req), 32'(exp_req));
            check("bus_err", 32'(bus_err), 32'(exp_err));
            check("mem_wreg", 32'(mem_wreg), 32'(exp_wreg));
            check("mem_wd", 32'(mem_wd), 32'(ex_wd));
            check("mem_whilo", 32'(mem_whilo), 32'(ex_whilo));
            check("mem_hi", mem_hi, ex_hi);
            check("mem_lo", mem_lo, ex_lo);
            if (exp_wdata_vld) begin
                check("mem_wdata", mem_wdata, exp_wdata);
                last_wdata = mem_wdata;
            end
            if (exp_req) begin
                check("dbus_addr", dbus.addr, exp_addr);
                check("dbus_sel", 32'(dbus.sel), 32'(exp_sel));
                check("dbus_we", 32'(dbus.we), 32'(exp_we));
                if (exp_store) check("dbus_wdata", dbus.wdata, exp_bwdata);
                last_addr = dbus.addr;
                last_sel = dbus.sel;
                last_we = dbus.we;
                last_bwdata = dbus.wdata;
            end
        end
    end

    // Called just after a rising edge; leaves the bench just after the edge that exits DONE.
    task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                          input logic [31:0] rdata, input int n_busy, input bit acked,
                          input int hold);
        bit ld, st, fault, done;
        int nb, n_cyc;
        ld = op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
        st = op inside {OP_SB, OP_SH, OP_SW};
        fault = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        fault = ((op inside {OP_LH, OP_LHU, OP_SH}) && addr[0]) ||
                ((op inside {OP_LW, OP_SW}) && (addr[1:0] != 2'b00));
`endif
        nb = fault ? 0 : n_busy;
        n_cyc = nb + 2 + hold;
        ex_aluop = op;
        ex_mem_addr = addr;
        ex_reg2 = reg2;
        ex_wd = 5'd7 ^ op[4:0];
        ex_wreg = ld;
        ex_wdata = 32'h0BAD_0000 ^ addr;
        ex_whilo = 1'b0;
        exp_store = st;
        exp_we = st;
        exp_addr = {addr[31:2], 2'b00};
        exp_sel = model_sel(op, addr);
        exp_bwdata = model_bwdata(op, reg2);
        exp_wdata = model_load(op, addr, rdata);
        for (int k = 0; k < n_cyc; k++) begin
            done = (k > nb);
            exp_stall = !done;
            exp_req = (k >= 1) && !done;
            exp_err = (k == nb + 1) && (fault || !acked);
            exp_wreg = done && ld && acked && !fault;
            exp_wdata_vld = exp_wreg;
            if (acked && nb >= 1 && k == nb) begin
                dbus.ack = 1'b1;
                dbus.rdata = rdata;
            end else begin
                // Acks outside BUSY carry junk data and must be ignored.
                dbus.ack = (k == 0) || done;
                dbus.rdata = ~rdata;
            end
            stall = (done && k < n_cyc - 1) ? 6'b010000 : 6'b000000;
            chk_en = 1'b1;
            @(posedge clk);
            #1;
        end
        dbus.ack = 1'b0;
        stall = 6'b000000;
    endtask

    task automatic set_nop(input logic [31:0] wdata);
        ex_aluop = OP_OR;
        ex_wd = 5'd3;
        ex_wreg = 1'b1;
        ex_wdata = wdata;
        ex_whilo = 1'b1;
        ex_hi = wdata ^ 32'hFFFF_0000;
        ex_lo = wdata ^ 32'h0000_FFFF;
        ex_mem_addr = wdata;
        ex_reg2 = 32'h0;
    endtask

    task automatic run_nop(input logic [31:0] wdata);
        set_nop(wdata);
        exp_stall = 1'b0;
        exp_req = 1'b0;
        exp_err = 1'b0;
        exp_wreg = 1'b1;
        exp_wdata_vld = 1'b1;
        exp_wdata = wdata;
        dbus.ack = 1'b1;
        dbus.rdata = ~wdata;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        dbus.ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        stall = 6'b000000;
        dbus.ack = 1'b0;
        dbus.rdata = 32'h0;
        set_nop(32'h0);
        #1;
        check("rst_req", 32'(dbus.req), 32'd0);
        check("rst_we", 32'(dbus.we), 32'd0);
        check("rst_addr", dbus.addr, 32'd0);
        check("rst_sel", 32'(dbus.sel), 32'd0);
        check("rst_wdata", dbus.wdata, 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_stallreq", 32'(stallreq), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        run_nop(32'h1234_5678);
        run_op(OP_LW, 32'h100, 32'h0, 32'h1122_3344, 2, 1'b1, 0);
        check("lit_lw", last_wdata, 32'h1122_3344);
        run_op(OP_LB, 32'h103, 32'h0, 32'h1122_33F4, 1, 1'b1, 0);
        check("lit_lb", last_wdata, 32'hFFFF_FFF4);
        run_op(OP_LBU, 32'h103, 32'h0, 32'h1122_33F4, 1, 1'b1, 0);
        check("lit_lbu", last_wdata, 32'h0000_00F4);
        run_op(OP_LH, 32'h100, 32'h0, 32'h8001_5555, 1, 1'b1, 0);
        check("lit_lh", last_wdata, 32'hFFFF_8001);
        run_op(OP_LHU, 32'h102, 32'h0, 32'h7FFF_8765, 2, 1'b1, 0);
        check("lit_lhu", last_wdata, 32'h0000_8765);
        run_op(OP_LB, 32'h101, 32'h0, 32'h1180_3344, 1, 1'b1, 0);
        check("lit_lb_lane1", last_wdata, 32'hFFFF_FF80);
        run_op(OP_SH, 32'h102, 32'hABCD_1234, 32'h0, 1, 1'b1, 0);
        check("lit_sh_sel", 32'(last_sel), 32'(4'b0011));
        check("lit_sh_wdata", last_bwdata, 32'h1234_1234);
        check("lit_sh_we", 32'(last_we), 32'd1);
        run_op(OP_SB, 32'h101, 32'h0000_005A, 32'h0, 3, 1'b1, 0);
        check("lit_sb_sel", 32'(last_sel), 32'(4'b0100));
        check("lit_sb_wdata", last_bwdata, 32'h5A5A_5A5A);
        run_op(OP_SW, 32'h104, 32'hCAFE_F00D, 32'h0, 1, 1'b1, 0);
        check("lit_sw_sel", 32'(last_sel), 32'(4'b1111));

        // No ack: 16 request cycles, then an error pulse and a suppressed write.
        run_op(OP_LW, 32'h200, 32'h0, 32'h0000_0055, 16, 1'b0, 0);
        // Ack on the final allowed cycle completes normally.
        run_op(OP_LW, 32'h204, 32'h0, 32'h0000_0077, 16, 1'b1, 0);
        check("lit_late_ack", last_wdata, 32'h0000_0077);
        // mem_wb held for three cycles in DONE; result must stay put.
        run_op(OP_LW, 32'h300, 32'h0, 32'hA5A5_5A5A, 1, 1'b1, 3);
        check("lit_hold", last_wdata, 32'hA5A5_5A5A);

        // Reset during BUSY drops the request at once and returns to IDLE.
        chk_en = 1'b0;
        ex_aluop = OP_LW;
        ex_mem_addr = 32'h500;
        ex_wreg = 1'b1;
        dbus.ack = 1'b0;
        @(posedge clk);
        #1;
        check("mid_busy_req", 32'(dbus.req), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_req", 32'(dbus.req), 32'd0);
        check("mid_rst_err", 32'(bus_err), 32'd0);
        @(posedge clk);
        #1;
        set_nop(32'h0F0F_0F0F);
        rst = 1'b1;
        #1;
        check("post_rst_stallreq", 32'(stallreq), 32'd0);
        check("post_rst_req", 32'(dbus.req), 32'd0);
        check("post_rst_wreg", 32'(mem_wreg), 32'd1);

        run_op(OP_LW, 32'h102, 32'h0, 32'h9988_7766, 1, 1'b1, 0);
`ifndef MEM_ALIGN_CHECK_EN
        check("lit_unaligned_addr", last_addr, 32'h0000_0100);
        check("lit_unaligned_data", last_wdata, 32'h9988_7766);
`endif
        run_nop(32'hDEAD_BEEF);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
